// File: rtl/instr_queue.sv
// Circular instruction queue between the frontend selector and issue; optional same-cycle
// empty-queue bypass when INSTR_QUEUE_BYPASS_EN is defined (default: 1-cycle minimum latency).
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [ILEN-1:0]            fetch_instr_i,
  input  logic                       fetch_pred_taken_i,
  input  logic [XLEN-1:0]            fetch_pred_target_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [XLEN-1:0]            issue_pc_o,
  output logic [ILEN-1:0]            issue_instr_o,
  output logic                       issue_pred_taken_o,
  output logic [XLEN-1:0]            issue_pred_target_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h13);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [CW-1:0] count;
  entry_t        fetch_ent, out_ent;
  logic          empty, full, push, wr, pop, byp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fetch_ent = '{pc: fetch_pc_i, instr: fetch_instr_i,
                       taken: fetch_pred_taken_i, target: fetch_pred_target_i};

  // Flags come from the registered count only, so a same-cycle pop never frees a slot.
  assign empty         = (count == '0);
  assign full          = (count == CW'(DEPTH));
  assign fetch_ready_o = !full && !flush_i && rst_n_i;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign byp = empty && !flush_i && fetch_valid_i && rst_n_i;
`else
  assign byp = 1'b0;
`endif

  assign issue_valid_o = (!empty && !flush_i) || byp;
  assign push          = fetch_valid_i && fetch_ready_o;
  // A bypassed instruction taken by issue this cycle is never stored.
  assign wr            = push && !(byp && issue_ready_i);
  assign pop           = !empty && !flush_i && issue_ready_i;

  always_comb begin
    out_ent = '{pc: '0, instr: NOP, taken: 1'b0, target: '0};
    if (!empty && !flush_i) begin
      out_ent = mem[head_ptr];
    end
`ifdef INSTR_QUEUE_BYPASS_EN
    else if (byp) begin
      out_ent = fetch_ent;
    end
`endif
  end

  assign issue_pc_o          = out_ent.pc;
  assign issue_instr_o       = out_ent.instr;
  assign issue_pred_taken_o  = out_ent.taken;
  assign issue_pred_target_o = out_ent.target;
  assign count_o             = count;

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem[tail_ptr] <= fetch_ent;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (wr)  tail_ptr <= nxt(tail_ptr);
      if (pop) head_ptr <= nxt(head_ptr);
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed table on DEPTH=8, randomized model comparison on DEPTH=5.
module tb_instr_queue;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [63:0] target;
  } ent_t;

  typedef struct {
    logic        flush, fv, ir;
    logic [63:0] pc;
    logic        er, ev;
    logic [63:0] epc;
    int          ecnt;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic flush, fv, fr, ftaken, ir, iv, itaken;
  logic [63:0] fpc, ftarget, ipc, itarget;
  logic [31:0] finstr, iinstr;
  logic [3:0]  cnt;
  // DEPTH=5 instance
  logic flush5, fv5, fr5, ftaken5, ir5, iv5, itaken5;
  logic [63:0] fpc5, ftarget5, ipc5, itarget5;
  logic [31:0] finstr5, iinstr5;
  logic [2:0]  cnt5;

  instr_queue #(.DEPTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .fetch_valid_i(fv), .fetch_ready_o(fr), .fetch_pc_i(fpc), .fetch_instr_i(finstr),
    .fetch_pred_taken_i(ftaken), .fetch_pred_target_i(ftarget),
    .issue_valid_o(iv), .issue_ready_i(ir), .issue_pc_o(ipc), .issue_instr_o(iinstr),
    .issue_pred_taken_o(itaken), .issue_pred_target_o(itarget), .count_o(cnt));

  instr_queue #(.DEPTH(5)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush5),
    .fetch_valid_i(fv5), .fetch_ready_o(fr5), .fetch_pc_i(fpc5), .fetch_instr_i(finstr5),
    .fetch_pred_taken_i(ftaken5), .fetch_pred_target_i(ftarget5),
    .issue_valid_o(iv5), .issue_ready_i(ir5), .issue_pc_o(ipc5), .issue_instr_o(iinstr5),
    .issue_pred_taken_o(itaken5), .issue_pred_target_o(itarget5), .count_o(cnt5));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return 32'h13 + 32'((pc - 64'h100) >> 2);
  endfunction

  task automatic drive(input logic fl, input logic v, input logic [63:0] pc, input logic r);
    flush = fl; fv = v; fpc = pc; finstr = ins_of(pc);
    ftaken = pc[2]; ftarget = pc + 64'h40; ir = r;
  endtask

  // Compare the DEPTH=8 outputs against an expected head (or idle NOP when not valid).
  task automatic chk8(input string nm, input logic er, input logic ev,
                      input logic [63:0] epc, input int ecnt);
    chk({nm, "_ready"}, 64'(fr), 64'(er));
    chk({nm, "_valid"}, 64'(iv), 64'(ev));
    chk({nm, "_count"}, 64'(cnt), 64'(ecnt));
    chk({nm, "_pc"}, ipc, ev ? epc : 64'h0);
    chk({nm, "_instr"}, 64'(iinstr), ev ? 64'(ins_of(epc)) : 64'h13);
    chk({nm, "_taken"}, 64'(itaken), ev ? 64'(epc[2]) : 64'h0);
    chk({nm, "_target"}, itarget, ev ? epc + 64'h40 : 64'h0);
  endtask

  function automatic vec_t mk(input logic fl, input logic v, input logic [63:0] pc,
                              input logic r, input logic er, input logic ev,
                              input logic [63:0] epc, input int ecnt);
    vec_t t;
    t.flush = fl; t.fv = v; t.pc = pc; t.ir = r;
    t.er = er; t.ev = ev; t.epc = epc; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tv[19];
  ent_t q[$];
  ent_t e, cur;
  logic [63:0] npc;
  logic byp, ev5, er5;

  initial begin
    // fill to full, refuse 9th, pop-while-full, drain to 3, flush with push of 0x200
    tv[0] = mk(0, 1, 64'h100, 0, 1, BYP, BYP ? 64'h100 : 64'h0, 0);
    for (int i = 1; i < 8; i++)
      tv[i] = mk(0, 1, 64'h100 + 64'(4 * i), 0, 1, 1, 64'h100, i);
    tv[8]  = mk(0, 1, 64'h120, 0, 0, 1, 64'h100, 8);
    tv[9]  = mk(0, 1, 64'h120, 1, 0, 1, 64'h100, 8);
    tv[10] = mk(0, 1, 64'h120, 0, 1, 1, 64'h104, 7);
    tv[11] = mk(0, 0, 64'h0,   0, 0, 1, 64'h104, 8);
    tv[12] = mk(0, 0, 64'h0,   1, 0, 1, 64'h104, 8);
    tv[13] = mk(0, 0, 64'h0,   1, 1, 1, 64'h108, 7);
    tv[14] = mk(0, 0, 64'h0,   1, 1, 1, 64'h10C, 6);
    tv[15] = mk(0, 0, 64'h0,   1, 1, 1, 64'h110, 5);
    tv[16] = mk(0, 0, 64'h0,   1, 1, 1, 64'h114, 4);
    tv[17] = mk(1, 1, 64'h200, 1, 0, 0, 64'h0,   3);
    tv[18] = mk(0, 0, 64'h0,   1, 1, 0, 64'h0,   0);

    drive(0, 1, 64'h100, 0);
    flush5 = 0; fv5 = 0; ir5 = 0; fpc5 = '0; finstr5 = '0; ftaken5 = 0; ftarget5 = '0;
    repeat (2) @(posedge clk);
    #1 chk8("reset", 0, 0, 64'h0, 0);
    drive(0, 0, 64'h0, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk8("release", 1, 0, 64'h0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].flush, tv[i].fv, tv[i].pc, tv[i].ir);
      @(negedge clk);
      chk8($sformatf("vec%0d", i), tv[i].er, tv[i].ev, tv[i].epc, tv[i].ecnt);
      @(posedge clk); #1;
    end

    // push 0x300 into empty queue with issue ready
    drive(0, 1, 64'h300, 1);
    @(negedge clk);
    chk8("lat_c0", 1, BYP, BYP ? 64'h300 : 64'h0, 0);
    @(posedge clk); #1;
    drive(0, 0, 64'h0, 1);
    @(negedge clk);
    chk8("lat_c1", 1, !BYP, BYP ? 64'h0 : 64'h300, BYP ? 0 : 1);
    @(posedge clk); #1;

    // four entries, then asynchronous mid-cycle reset
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 64'h400 + 64'(4 * i), 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 64'h0, 0);
    chk8("pre_arst", 1, 1, 64'h400, 4);
    #2 rst_n = 1'b0;
    #1 chk8("arst", 0, 0, 64'h0, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk8("arst_rel", 1, 0, 64'h0, 0);
    @(posedge clk); #1;

    // randomized stream on DEPTH=5 against a queue model
    npc = 64'h100;
    for (int c = 0; c < 600; c++) begin
      flush5   = (c >= 60) && ($urandom_range(0, 19) == 0);
      fv5      = ($urandom_range(0, 3) != 0);
      ir5      = (c < 60) ? c[0] : 1'($urandom_range(0, 1));
      fpc5     = npc;
      finstr5  = $urandom;
      ftaken5  = 1'($urandom_range(0, 1));
      ftarget5 = {$urandom, $urandom};
      cur      = '{pc: fpc5, instr: finstr5, taken: ftaken5, target: ftarget5};
      byp = BYP && (q.size() == 0) && !flush5 && fv5;
      ev5 = ((q.size() != 0) && !flush5) || byp;
      er5 = (q.size() < 5) && !flush5;
      e   = (q.size() != 0) ? q[0] : cur;
      @(negedge clk);
      chk("r_ready", 64'(fr5), 64'(er5));
      chk("r_valid", 64'(iv5), 64'(ev5));
      chk("r_count", 64'(cnt5), 64'(q.size()));
      chk("r_pc", ipc5, ev5 ? e.pc : 64'h0);
      chk("r_instr", 64'(iinstr5), ev5 ? 64'(e.instr) : 64'h13);
      chk("r_taken", 64'(itaken5), ev5 ? 64'(e.taken) : 64'h0);
      chk("r_target", itarget5, ev5 ? e.target : 64'h0);
      @(posedge clk);
      if (flush5) begin
        q.delete();
      end else if (byp && ir5) begin
        npc += 4;
      end else begin
        if (ev5 && ir5) void'(q.pop_front());
        if (fv5 && er5) begin
          q.push_back(cur);
          npc += 4;
        end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
